up_sampler: RTL and testbench



---
 rtl/up_sampler_pkg.sv | 19 +
 rtl/line_buffer_ram.sv | 35 +++
 rtl/up_sampler.sv | 182 ++++++++++++++++++
 tb/tb_up_sampler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/up_sampler_pkg.sv
`default_nettype none
// ============================================================================
// up_sampler_pkg : shared state encoding and constants for the up-sampler.
// Rev 1.0
// ============================================================================
package up_sampler_pkg;

  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic [0:0] {
    FILL   = 1'b0,
    REPLAY = 1'b1
  } state_e;

  localparam logic COPY0 = 1'b0;
  localparam logic COPY1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/line_buffer_ram.sv
`default_nettype none
// ============================================================================
// line_buffer_ram : simple dual-port line store, sync write, 1-cycle sync read.
// Rev 1.0
// ============================================================================
module line_buffer_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/up_sampler.sv
`default_nettype none
// ============================================================================
// up_sampler : 2x nearest-neighbour up-sampler (pixels and lines doubled).
// Optional horizontal interpolation of copy 0 under UP_SAMPLER_HINTERP_EN.
// Rev 1.0
// ============================================================================
module up_sampler
  import up_sampler_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEFAULT,
  parameter int IN_WIDTH  = 64,
  parameter int IN_HEIGHT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              empty,
  output logic              rd_en,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  output logic              dout_valid,
  output logic [DATA_W-1:0] dout,
  input  logic              dout_ready,
  output logic              eol,
  output logic              eof
);

  localparam int COL_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int ROW_W = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IN_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IN_HEIGHT - 1);

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              pend_q, pend_d;
  logic              rpend_q, rpend_d;
  logic              copy_q, copy_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              eol_q, eol_d;
  logic              eof_q, eof_d;

  logic              accept;
  logic              last_col;
  logic              last_row;
  logic              pair_done;
  logic              slot_free;
  logic              fifo_rd;
  logic              lb_rd;
  logic              fifo_hit;
  logic              new_valid;
  logic [DATA_W-1:0] new_pix;
  logic [DATA_W-1:0] copy0_pix;
  logic [DATA_W-1:0] lb_rd_data;

  assign accept    = dout_valid_q && dout_ready;
  assign last_col  = (col_q == LAST_COL);
  assign last_row  = (row_q == LAST_ROW);
  assign pair_done = accept && (copy_q == COPY1);
  // A new pixel may be fetched only once the held pair has gone out, and never past line end.
  assign slot_free = !dout_valid_q || (pair_done && !last_col);
  assign fifo_rd   = rst && (state_q == FILL) && !empty && !pend_q && slot_free;
  assign lb_rd     = rst && (state_q == REPLAY) && !rpend_q && slot_free;
  assign fifo_hit  = (state_q == FILL) && pend_q && din_valid;
  assign new_valid = fifo_hit || rpend_q;
  assign new_pix   = fifo_hit ? din : lb_rd_data;

`ifdef UP_SAMPLER_HINTERP_EN
  logic [DATA_W-1:0] pix_q, pix_d;
  logic [DATA_W:0]   pair_sum;

  assign pair_sum  = {1'b0, pix_q} + {1'b0, new_pix} + {{DATA_W{1'b0}}, 1'b1};
  assign copy0_pix = (col_q == '0) ? new_pix : pair_sum[DATA_W:1];
  assign pix_d     = new_valid ? new_pix : pix_q;

  always_ff @(posedge clk) begin
    pix_q <= pix_d;
  end
`else
  assign copy0_pix = new_pix;
`endif

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    copy_d       = copy_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    eol_d        = eol_q;
    eof_d        = eof_q;
    pend_d       = pend_q;
    rpend_d      = lb_rd;

    if (fifo_rd) begin
      pend_d = 1'b1;
    end else if (fifo_hit) begin
      pend_d = 1'b0;
    end

    if (new_valid) begin
      dout_d       = copy0_pix;
      dout_valid_d = 1'b1;
      copy_d       = COPY0;
      eol_d        = 1'b0;
      eof_d        = 1'b0;
    end else if (accept) begin
      if (copy_q == COPY0) begin
        copy_d = COPY1;
`ifdef UP_SAMPLER_HINTERP_EN
        dout_d = pix_q;
`endif
        eol_d  = last_col;
        eof_d  = last_col && last_row && (state_q == REPLAY);
      end else begin
        dout_valid_d = 1'b0;
        eol_d        = 1'b0;
        eof_d        = 1'b0;
        if (last_col) begin
          col_d = '0;
          if (state_q == FILL) begin
            state_d = REPLAY;
          end else begin
            state_d = FILL;
            row_d   = last_row ? '0 : row_q + ROW_W'(1);
          end
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= FILL;
      col_q        <= '0;
      row_q        <= '0;
      pend_q       <= 1'b0;
      rpend_q      <= 1'b0;
      copy_q       <= COPY0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      eol_q        <= 1'b0;
      eof_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      pend_q       <= pend_d;
      rpend_q      <= rpend_d;
      copy_q       <= copy_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      eol_q        <= eol_d;
      eof_q        <= eof_d;
    end
  end

  // The read address is the column that will be current after this edge.
  line_buffer_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (IN_WIDTH),
    .ADDR_W (COL_W)
  ) u_line_buffer_ram (
    .clk     (clk),
    .wr_en   (fifo_hit),
    .wr_addr (col_q),
    .wr_data (din),
    .rd_en   (lb_rd),
    .rd_addr (col_d),
    .rd_data (lb_rd_data)
  );

  assign rd_en      = fifo_rd;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign eol        = eol_q;
  assign eof        = eof_q;

endmodule
`default_nettype wire

// File: tb/tb_up_sampler.sv
`default_nettype none
// ============================================================================
// tb_up_sampler : scoreboard bench for up_sampler (IN_WIDTH=4, IN_HEIGHT=2).
// Rev 1.0
// ============================================================================
module tb_up_sampler;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 2;
`ifdef UP_SAMPLER_HINTERP_EN
  localparam bit INTERP = 1'b1;
`else
  localparam bit INTERP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          empty;
  logic          rd_en;
  logic          din_valid;
  logic [DW-1:0] din;
  logic          dout_valid;
  logic [DW-1:0] dout;
  logic          dout_ready;
  logic          eol;
  logic          eof;

  always #5 clk = ~clk;

  up_sampler #(
    .DATA_W    (DW),
    .IN_WIDTH  (W),
    .IN_HEIGHT (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .empty      (empty),
    .rd_en      (rd_en),
    .din_valid  (din_valid),
    .din        (din),
    .dout_valid (dout_valid),
    .dout       (dout),
    .dout_ready (dout_ready),
    .eol        (eol),
    .eof        (eof)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          e;
    logic          f;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] fr [W*H];
  int            n_cmp    = 0;
  int            n_bad    = 0;
  int            beat_cnt = 0;
  bit            spur     = 1'b0;

  function automatic logic [DW-1:0] copy0_val(input logic [DW-1:0] prv, input logic [DW-1:0] cur,
                                              input int i);
    logic [DW:0] s;
    s = {1'b0, prv} + {1'b0, cur} + 9'd1;
    return (INTERP && i > 0) ? s[DW:1] : cur;
  endfunction

  // Queue the expected beats for the whole frame in fr; feed the first nfifo pixels.
  task automatic push_frame(input int nfifo);
    beat_t b;
    for (int l = 0; l < H; l++) begin
      for (int rep = 0; rep < 2; rep++) begin
        for (int i = 0; i < W; i++) begin
          b.d = copy0_val((i > 0) ? fr[l*W+i-1] : fr[l*W+i], fr[l*W+i], i);
          b.e = 1'b0;
          b.f = 1'b0;
          exp_q.push_back(b);
          b.d = fr[l*W+i];
          b.e = (i == W-1);
          b.f = (i == W-1) && (rep == 1) && (l == H-1);
          exp_q.push_back(b);
        end
      end
    end
    for (int k = 0; k < nfifo; k++) fifo_q.push_back(fr[k]);
  endtask

  task automatic feed(input int from, input int to);
    for (int k = from; k < to; k++) fifo_q.push_back(fr[k]);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while (exp_q.size() > 0 && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s drain timeout: got %0d beats left, required 0", nm, exp_q.size());
    end
  endtask

  task automatic wait_beats(input string nm, input int target);
    int k = 0;
    while (beat_cnt < target && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    if (beat_cnt < target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s wait timeout: got %0d beats, required %0d", nm, beat_cnt, target);
    end
  endtask

  // FIFO model: pop on rd_en, data valid the cycle after.
  initial begin : fifo_model
    bit            take;
    logic [DW-1:0] v;
    din_valid = 1'b0;
    din       = '0;
    empty     = 1'b1;
    v         = '0;
    forever begin
      @(negedge clk);
      take = rd_en && (fifo_q.size() > 0);
      if (take) v = fifo_q.pop_front();
      @(posedge clk); #1;
      if (take) begin
        din_valid = 1'b1;
        din       = v;
      end else if (spur) begin
        din_valid = 1'b1;
        din       = 8'd99;
        spur      = 1'b0;
      end else begin
        din_valid = 1'b0;
      end
      empty = (fifo_q.size() == 0);
    end
  end

  always @(negedge clk) begin : monitor
    beat_t e;
    if (dout_valid && dout_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL beat_unexpected: got dout=%0d eol=%b eof=%b, required no beat", dout, eol, eof);
      end else begin
        e = exp_q.pop_front();
        if (dout !== e.d || eol !== e.e || eof !== e.f) begin
          n_bad++;
          $display("FAIL beat_%0d: got dout=%0d eol=%b eof=%b, required dout=%0d eol=%b eof=%b",
                   beat_cnt, dout, eol, eof, e.d, e.e, e.f);
        end
      end
      beat_cnt++;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int base;
    rst        = 1'b0;
    dout_ready = 1'b1;

    fr = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
    repeat (2) @(posedge clk);
    #1 push_frame(W*H);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_dout_valid", 32'(dout_valid), 0);
    chk("reset_rd_en", 32'(rd_en), 0);
    chk("reset_eol", 32'(eol), 0);
    chk("reset_eof", 32'(eof), 0);
    chk("reset_dout", 32'(dout), 0);
    @(posedge clk); #1 rst = 1'b1;

    drain("nominal");

    base = beat_cnt;
    push_frame(W*H);
    wait_beats("bp", base + 3);
    dout_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_dout", 32'(dout), 20);
      chk("bp_valid", 32'(dout_valid), 1);
      chk("bp_eol", 32'(eol), 0);
      chk("bp_rd_en", 32'(rd_en), 0);
    end
    @(posedge clk); #1 dout_ready = 1'b1;
    drain("backpressure");

    base = beat_cnt;
    push_frame(2);
    wait_beats("starve", base + 4);
    repeat (4) begin
      @(negedge clk);
      chk("starve_valid", 32'(dout_valid), 0);
      chk("starve_rd_en", 32'(rd_en), 0);
    end
    @(posedge clk); #1 feed(2, W*H);
    drain("starvation");

    @(negedge clk) spur = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("spur_valid", 32'(dout_valid), 0);
    end
    fr = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd200, 8'd255, 8'd0, 8'd1};
    push_frame(W*H);
    drain("after_spurious");

    fr = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
    base = beat_cnt;
    push_frame(W*H);
    wait_beats("rst_mid", base + 12);
    rst = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    fifo_q.delete();
    @(negedge clk);
    chk("rstmid_valid", 32'(dout_valid), 0);
    chk("rstmid_rd_en", 32'(rd_en), 0);
    chk("rstmid_eol", 32'(eol), 0);
    chk("rstmid_eof", 32'(eof), 0);
    spur = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(dout_valid), 0);
    end
    fr = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd200, 8'd255, 8'd0, 8'd1};
    push_frame(W*H);
    drain("after_reset");

    repeat (10) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
